// File: rtl/anita3_trig_pkg.sv
// Shared constants for the ANITA-3 trigger scheduler: source bit indices,
// scheduler states and default sizing.
package anita3_trig_pkg;

  localparam int TRIG_RF   = 0;
  localparam int TRIG_EXT  = 1;
  localparam int TRIG_PPS  = 2;
  localparam int TRIG_SOFT = 3;
  localparam int NUM_SRC   = 4;

  localparam int DEF_NUM_PHI = 16;
  localparam int DEF_NUM_BUF = 4;
  localparam int DEF_HOLDOFF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FULL = 2'd2
  } sched_state_t;

  // Buffer index width; kept at least one bit wide.
  function automatic int buf_idx_width(input int num_buf);
    return (num_buf > 1) ? $clog2(num_buf) : 1;
  endfunction

endpackage

// File: rtl/anita3_trigger_scheduler_if.sv
// Trigger bus between the scheduler (master) and the event readout (slave),
// including the buffer-release return path.
interface anita3_trigger_scheduler_if
  import anita3_trig_pkg::*;
#(
  parameter int NUM_PHI = DEF_NUM_PHI,
  parameter int NUM_BUF = DEF_NUM_BUF
);
  localparam int BUF_W = buf_idx_width(NUM_BUF);

  logic                 trig_o;
  logic [NUM_SRC-1:0]   trig_type_o;
  logic [BUF_W-1:0]     trig_buf_o;
  logic [2*NUM_PHI-1:0] phi_o;
  logic [31:0]          event_id_o;
  logic                 buf_release_i;

  modport master (
    output trig_o, trig_type_o, trig_buf_o, phi_o, event_id_o,
    input  buf_release_i
  );

  modport slave (
    input  trig_o, trig_type_o, trig_buf_o, phi_o, event_id_o,
    output buf_release_i
  );

endinterface

// File: rtl/anita3_buffer_credit.sv
// Readout buffer credit counter with wrapping buffer pointer; full when no
// credits remain.
module anita3_buffer_credit
  import anita3_trig_pkg::*;
#(
  parameter int NUM_BUF = DEF_NUM_BUF
) (
  input  logic                              clk250_i,
  input  logic                              rst_i,
  input  logic                              take_i,
  input  logic                              release_i,
  output logic [buf_idx_width(NUM_BUF)-1:0] ptr_o,
  output logic                              full_o
);
  localparam int BUF_W  = buf_idx_width(NUM_BUF);
  localparam int CRED_W = $clog2(NUM_BUF + 1);

  logic [CRED_W-1:0] credits_reg, credits_next;
  logic [BUF_W-1:0]  ptr_reg;

  // Release is dropped when every buffer is already free.
  always_comb begin
    credits_next = credits_reg;
    if (take_i && !release_i)
      credits_next = credits_reg - CRED_W'(1);
    else if (!take_i && release_i && credits_reg != CRED_W'(NUM_BUF))
      credits_next = credits_reg + CRED_W'(1);
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      credits_reg <= CRED_W'(NUM_BUF);
      ptr_reg     <= '0;
    end else begin
      credits_reg <= credits_next;
      if (take_i)
        ptr_reg <= ptr_reg + BUF_W'(1);
    end
  end

  assign ptr_o  = ptr_reg;
  assign full_o = (credits_reg == '0);

endmodule

// File: rtl/anita3_trigger_scheduler.sv
// Merges RF, external, PPS and software triggers into one readout trigger
// stream with holdoff, buffer credits, event IDs and deadtime/loss scalers.
module anita3_trigger_scheduler
  import anita3_trig_pkg::*;
#(
  parameter int NUM_PHI = DEF_NUM_PHI,
  parameter int NUM_BUF = DEF_NUM_BUF,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic                       clk250_i,
  input  logic                       rst_i,
  input  logic                       rf_trig_i,
  input  logic [2*NUM_PHI-1:0]       rf_phi_i,
  input  logic                       ext_trig_i,
  input  logic                       pps_trig_i,
  input  logic                       soft_trig_i,
  input  logic [NUM_SRC-1:0]         trig_en_i,
  input  logic                       scal_clr_i,
  anita3_trigger_scheduler_if.master rd_if,
  output logic                       busy_o,
  output logic [15:0]                dead_cnt_o,
  output logic [15:0]                lost_cnt_o
);
  localparam int BUF_W = buf_idx_width(NUM_BUF);

  logic [NUM_SRC-1:0]   src_s1_reg, en_s1_reg, req;
  logic                 rf_s2_reg, rf_edge;
  logic [2*NUM_PHI-1:0] phi_s1_reg, phi_reg;
  sched_state_t         state_reg, state_next;
  logic [7:0]           hold_reg, hold_next;
  logic                 ready, issue, full;
  logic [BUF_W-1:0]     ptr;
  logic                 trig_reg;
  logic [NUM_SRC-1:0]   type_reg;
  logic [BUF_W-1:0]     buf_reg;
  logic [31:0]          event_id_reg;
  logic [15:0]          dead_reg, lost_reg;

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      src_s1_reg <= '0;
      en_s1_reg  <= '0;
      rf_s2_reg  <= 1'b0;
      phi_s1_reg <= '0;
    end else begin
      src_s1_reg <= {soft_trig_i, pps_trig_i, ext_trig_i, rf_trig_i};
      en_s1_reg  <= trig_en_i;
      rf_s2_reg  <= src_s1_reg[TRIG_RF];
      phi_s1_reg <= rf_phi_i;
    end
  end

  assign rf_edge = src_s1_reg[TRIG_RF] & ~rf_s2_reg & en_s1_reg[TRIG_RF];

  // RF is never queued; the pulsed sources keep a one-deep pending flag.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    if (gi == TRIG_RF) begin : g_rf
      assign req[gi] = rf_edge;
    end else begin : g_pend
      logic pend_reg;
      always_ff @(posedge clk250_i or posedge rst_i) begin
        if (rst_i)                 pend_reg <= 1'b0;
        else if (!en_s1_reg[gi])   pend_reg <= 1'b0;
        else if (issue)            pend_reg <= 1'b0;
        else if (src_s1_reg[gi])   pend_reg <= 1'b1;
      end
      assign req[gi] = pend_reg | (src_s1_reg[gi] & en_s1_reg[gi]);
    end
  end

  // The last holdoff cycle counts as the first idle cycle, so consecutive
  // triggers are spaced exactly HOLDOFF+1 cycles apart.
  assign ready = ~full & ((state_reg == IDLE) ||
                          (state_reg == HOLD && hold_reg == 8'd0));
  assign issue = ready & (|req);

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: ;
      HOLD: begin
        if (hold_reg != 8'd0) hold_next  = hold_reg - 8'd1;
        else if (full)        state_next = FULL;
        else                  state_next = IDLE;
      end
      FULL: if (!full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (issue) begin
      state_next = HOLD;
      hold_next  = 8'(HOLDOFF);
    end
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  anita3_buffer_credit #(.NUM_BUF(NUM_BUF)) u_credit (
    .clk250_i  (clk250_i),
    .rst_i     (rst_i),
    .take_i    (issue),
    .release_i (rd_if.buf_release_i),
    .ptr_o     (ptr),
    .full_o    (full)
  );

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      trig_reg     <= 1'b0;
      type_reg     <= '0;
      buf_reg      <= '0;
      phi_reg      <= '0;
      event_id_reg <= '0;
      dead_reg     <= '0;
      lost_reg     <= '0;
    end else begin
      trig_reg <= issue;
      if (issue) begin
        type_reg     <= req;
        buf_reg      <= ptr;
        phi_reg      <= req[TRIG_RF] ? phi_s1_reg : '0;
        event_id_reg <= event_id_reg + 32'd1;
      end
      if (scal_clr_i)                            dead_reg <= '0;
      else if (busy_o && dead_reg != 16'hFFFF)   dead_reg <= dead_reg + 16'd1;
      if (scal_clr_i)                            lost_reg <= '0;
      else if (rf_edge && !ready && lost_reg != 16'hFFFF)
                                                 lost_reg <= lost_reg + 16'd1;
    end
  end

  assign busy_o           = (state_reg != IDLE);
  assign dead_cnt_o       = dead_reg;
  assign lost_cnt_o       = lost_reg;
  assign rd_if.trig_o      = trig_reg;
  assign rd_if.trig_type_o = type_reg;
  assign rd_if.trig_buf_o  = buf_reg;
  assign rd_if.phi_o       = phi_reg;
  assign rd_if.event_id_o  = event_id_reg;

endmodule
